qbus_virq_arb: RTL and testbench
================================

Name: qbus_virq_arb

Overview:
- Synthesizable QBUS vectored-interrupt arbiter for the F-11 external-bus system.
- Collects level interrupt requests from up to NREQ on-board peripherals (console TX/RX, timer, …) and drives the CPU's inverted VIRQ line.
- Answers the IAKO/DIN vector-read cycle by putting the winner's vector on AD and sequencing RPLY, then issues a one-cycle acknowledge back to the winning peripheral.

Parameters:
- NREQ, 4, number of requesters (1..8); index 0 is highest priority.
- RR, 0, 0 = fixed priority; 1 = round-robin starting after last granted index.
- RPLY_DLY, 2, clocks between vector driven on AD and RPLY assertion (1..7).

Ports:
- pin_clk, in, 1, system clock.
- pin_init_n, in, 1, asynchronous active-low reset.
- irq_req, in, NREQ, level request per peripheral; active high.
- irq_vec, in, NREQ*7, vector bits [8:2] per requester, packed with requester i at [7i+6:7i].
- irq_ack, out, NREQ, one-clock grant pulse to the serviced requester.
- pin_din_n, in, 1, bus DIN; asynchronous, active low.
- pin_iako_n, in, 1, bus IAKO; asynchronous, active low.
- pin_virq_n, out, 1, interrupt request to CPU; active low.
- ad_out, out, 16, vector data, true polarity; pad inverts.
- ad_oe, out, 1, AD output enable.
- pin_rply_n, out, 1, reply; active low; pad is open-drain.

Behaviour:
- Reset, async while pin_init_n=0:
  - state IDLE, pin_virq_n=1, pin_rply_n=1, ad_oe=0, ad_out=0, irq_ack=0.
  - RR pointer=0; synchronizers preset to 1.
- din_n and iako_n pass through 2-FF synchronizers; all decisions use the synchronized values (din_s, iako_s).
- pin_virq_n is registered: 0 when state ∈ {IDLE, PEND} and |irq_req=1; otherwise 1.
- Latency: request rise to VIRQ low is one clock.
- States:
  - IDLE: |irq_req=1 -> PEND.
  - PEND:
    - If |irq_req=0, return to IDLE; the request was withdrawn and VIRQ is released.
    - On din_s=0 & iako_s=0: latch winner w and its vector; if no request is active at that moment, go to NORESP instead. Otherwise ad_out={7'b0, vec[w], 2'b00}, ad_oe=1, counter=RPLY_DLY -> VEC.
  - VEC:
    - Counter decrements each clock; at 0, pin_rply_n=0 -> HOLD.
    - If din_s or iako_s rises before the counter expires (aborted cycle) -> REL without asserting RPLY.
  - HOLD: wait for din_s=1. Then pin_rply_n=1, ad_oe=0, irq_ack[w]=1 for one clock. In RR mode, pointer=w+1 mod NREQ. -> REL.
  - REL: wait for iako_s=1 -> IDLE. This stops a still-low IAKO from retriggering the arbiter.
  - NORESP: never drive AD or RPLY; the CPU times out. Wait din_s=1 & iako_s=1 -> IDLE.
- Arbitration:
  - Fixed mode: lowest index with irq_req=1 wins.
  - RR mode: first set bit scanning from pointer upward, wrapping at NREQ-1 -> 0.
  - Winner is frozen from the DIN/IAKO latch until return to IDLE. Requests arriving later wait for the next round.
- Simultaneous events:
  - A request deasserting in the same clock as the latch is sampled as absent.
  - irq_ack to a requester that has already dropped is still issued; the peripheral ignores it.
- Peripherals must drop irq_req within 2 clocks of irq_ack. A level still high after REL re-arbitrates normally.
- pin_init_n asserted mid-cycle releases AD and RPLY asynchronously, with no ack pulse.

Decomposition:
- Shared package qbus_pkg: state encoding constants (IDLE, PEND, VEC, HOLD, REL, NORESP) and vector-field width constant QB_VEC_W=7.
- One sub-module, qbus_prio_enc: NREQ-wide priority encoder with rotate-by-pointer input. Outputs a valid flag and winner index; shared with the future DMA grant arbiter.

Test Plan:
- Single request: irq_req=4'b0010, vec1=7'o15 (vector 064). VIRQ low in 1 clk. IAKO+DIN low -> ad_out=16'o000064, ad_oe=1, RPLY low exactly RPLY_DLY+2 clks after strobes (2 sync + delay). DIN high -> RPLY high, irq_ack=4'b0010 one clock.
- Fixed priority: irq_req=4'b1010 with vectors 060/064/070/074. First cycle returns 064; after req1 drops, second cycle returns 074.
- RR=1, irq_req=4'b1111 held, four IAKO cycles: vectors in order for indices 0,1,2,3; fifth cycle wraps to 0. Ack pulses match.
- Withdrawal: req0 high 3 clks then low before IAKO -> VIRQ returns high, state IDLE. IAKO+DIN issued anyway -> no RPLY, no ad_oe within 50 clks (NORESP); recovery to IDLE after both high.
- Abort: DIN rises while in VEC with RPLY_DLY=5 -> RPLY never asserted, ad_oe drops, no irq_ack.
- Reset mid-cycle: pin_init_n low during HOLD -> pin_rply_n=1 and ad_oe=0 asynchronously, pin_virq_n=1, no ack pulse. After release, a pending request re-raises VIRQ.

Source files
------------

// File: rtl/qbus_pkg.sv
// Shared QBUS definitions: arbiter state encoding, vector-field width, index-width helper.
package qbus_pkg;

    localparam int QB_VEC_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_VEC,
        ST_HOLD,
        ST_REL,
        ST_NORESP
    } qb_state_e;

    function automatic int qb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qbus_prio_enc.sv
// Priority encoder with rotating start point: the first set request at or above ptr
// (wrapping at NREQ-1) wins. With ptr held at 0 it is a plain lowest-index encoder.
module qbus_prio_enc
    import qbus_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = qb_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set request is assigned last.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                vld = 1'b1;
                idx = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/qbus_virq_arb.sv
// QBUS vectored-interrupt arbiter: raises VIRQ for on-board requesters, answers the
// IAKO/DIN vector read with the winner's vector and RPLY, then pulses irq_ack.
module qbus_virq_arb
    import qbus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int RR       = 0,
    parameter int RPLY_DLY = 2
) (
    input  logic                     pin_clk,
    input  logic                     pin_init_n,
    input  logic [NREQ-1:0]          irq_req,
    input  logic [NREQ*QB_VEC_W-1:0] irq_vec,
    output logic [NREQ-1:0]          irq_ack,
    input  logic                     pin_din_n,
    input  logic                     pin_iako_n,
    output logic                     pin_virq_n,
    output logic [15:0]              ad_out,
    output logic                     ad_oe,
    output logic                     pin_rply_n
);

    localparam int IDX_W = qb_idx_w(NREQ);

    logic                din_s1, din_s, iako_s1, iako_s;
    logic                iack_s, any_req;
    qb_state_e           state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [IDX_W-1:0]    win, win_nxt, ptr, ptr_nxt;
    logic                enc_vld;
    logic [IDX_W-1:0]    enc_idx;
    logic [QB_VEC_W-1:0] vec_sel;
    logic                virq_nxt, rply_nxt, oe_nxt;
    logic [15:0]         ad_nxt;
    logic [NREQ-1:0]     ack_nxt;

    assign iack_s  = !din_s && !iako_s;
    assign any_req = |irq_req;

    qbus_prio_enc #(.NREQ(NREQ), .IDX_W(IDX_W)) u_enc (
        .req (irq_req),
        .ptr (ptr),
        .vld (enc_vld),
        .idx (enc_idx)
    );

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (enc_idx == IDX_W'(i)) vec_sel = irq_vec[QB_VEC_W*i +: QB_VEC_W];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        win_nxt   = win;
        ptr_nxt   = ptr;
        rply_nxt  = pin_rply_n;
        oe_nxt    = ad_oe;
        ad_nxt    = ad_out;
        ack_nxt   = '0;
        case (state)
            // A vector cycle already running while idle belongs to another device.
            ST_IDLE: begin
                if (iack_s)       state_nxt = ST_NORESP;
                else if (any_req) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (iack_s) begin
                    if (enc_vld) begin
                        win_nxt   = enc_idx;
                        ad_nxt    = {7'b0, vec_sel, 2'b00};
                        oe_nxt    = 1'b1;
                        cnt_nxt   = 3'(RPLY_DLY);
                        state_nxt = ST_VEC;
                    end else begin
                        state_nxt = ST_NORESP;
                    end
                end else if (!any_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_VEC: begin
                if (din_s || iako_s) begin
                    oe_nxt    = 1'b0;
                    ad_nxt    = '0;
                    state_nxt = ST_REL;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt_nxt == 3'd0) begin
                        rply_nxt  = 1'b0;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (din_s) begin
                    rply_nxt  = 1'b1;
                    oe_nxt    = 1'b0;
                    ad_nxt    = '0;
                    ack_nxt   = NREQ'(1) << win;
                    if (RR != 0) ptr_nxt = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (iako_s) state_nxt = ST_IDLE;
            end
            ST_NORESP: begin
                if (din_s && iako_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        virq_nxt = !(any_req && (state_nxt == ST_IDLE || state_nxt == ST_PEND));
    end

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            din_s1     <= 1'b1;
            din_s      <= 1'b1;
            iako_s1    <= 1'b1;
            iako_s     <= 1'b1;
            state      <= ST_IDLE;
            ptr        <= '0;
            pin_virq_n <= 1'b1;
            pin_rply_n <= 1'b1;
            ad_oe      <= 1'b0;
            ad_out     <= '0;
            irq_ack    <= '0;
        end else begin
            din_s1     <= pin_din_n;
            din_s      <= din_s1;
            iako_s1    <= pin_iako_n;
            iako_s     <= iako_s1;
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            pin_virq_n <= virq_nxt;
            pin_rply_n <= rply_nxt;
            ad_oe      <= oe_nxt;
            ad_out     <= ad_nxt;
            irq_ack    <= ack_nxt;
        end
    end

    // Winner and delay counter are only read after being loaded in PEND.
    always_ff @(posedge pin_clk) begin
        win <= win_nxt;
        cnt <= cnt_nxt;
    end

endmodule

// File: tb/tb_qbus_virq_arb.sv
// Directed bench for qbus_virq_arb: fixed-priority, round-robin and long-delay instances.
module tb_qbus_virq_arb;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            init_n, din_n, iako_n;
    logic [N-1:0]    req    [3];
    logic [7*N-1:0]  vec    [3];
    logic [N-1:0]    ack    [3];
    logic            virq_n [3];
    logic            rply_n [3];
    logic            oe     [3];
    logic [15:0]     ad     [3];
    int              dly    [3];
    int              tests = 0;
    int              fails = 0;

    qbus_virq_arb #(.NREQ(N), .RR(0), .RPLY_DLY(2)) u_fp (
        .pin_clk(clk), .pin_init_n(init_n), .irq_req(req[0]), .irq_vec(vec[0]),
        .irq_ack(ack[0]), .pin_din_n(din_n), .pin_iako_n(iako_n), .pin_virq_n(virq_n[0]),
        .ad_out(ad[0]), .ad_oe(oe[0]), .pin_rply_n(rply_n[0]));

    qbus_virq_arb #(.NREQ(N), .RR(1), .RPLY_DLY(2)) u_rr (
        .pin_clk(clk), .pin_init_n(init_n), .irq_req(req[1]), .irq_vec(vec[1]),
        .irq_ack(ack[1]), .pin_din_n(din_n), .pin_iako_n(iako_n), .pin_virq_n(virq_n[1]),
        .ad_out(ad[1]), .ad_oe(oe[1]), .pin_rply_n(rply_n[1]));

    qbus_virq_arb #(.NREQ(N), .RR(0), .RPLY_DLY(5)) u_ab (
        .pin_clk(clk), .pin_init_n(init_n), .irq_req(req[2]), .irq_vec(vec[2]),
        .irq_ack(ack[2]), .pin_din_n(din_n), .pin_iako_n(iako_n), .pin_virq_n(virq_n[2]),
        .ad_out(ad[2]), .ad_oe(oe[2]), .pin_rply_n(rply_n[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete vector-read cycle against instance d.
    task automatic iack_cycle(input int d, input logic [15:0] exp_ad, input logic [N-1:0] exp_ack,
                              input logic [N-1:0] drop, input string tag);
        int n;
        @(negedge clk);
        din_n  = 1'b0;
        iako_n = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        while (rply_n[d] !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " rply latency"}, n, dly[d] + 2);
        check({tag, " ad_oe"}, oe[d], 1);
        check({tag, " ad_out"}, ad[d], exp_ad);
        @(negedge clk);
        din_n = 1'b1;
        n = 0;
        while (ack[d] === '0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " ack"}, ack[d], exp_ack);
        check({tag, " rply release"}, rply_n[d], 1);
        check({tag, " ad_oe release"}, oe[d], 0);
        req[d] = req[d] & ~drop;
        @(posedge clk);
        #1;
        check({tag, " ack one clock"}, ack[d], 0);
        @(negedge clk);
        iako_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_r, seen_o, seen_a;
        dly    = '{2, 2, 5};
        init_n = 1'b0;
        din_n  = 1'b1;
        iako_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            vec[d] = {7'o17, 7'o16, 7'o15, 7'o14};
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset virq_n", virq_n[d], 1);
            check("reset rply_n", rply_n[d], 1);
            check("reset ad_oe", oe[d], 0);
            check("reset ad_out", ad[d], 0);
            check("reset ack", ack[d], 0);
        end
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, vector 064
        req[0] = 4'b0010;
        #1;
        check("single virq before edge", virq_n[0], 1);
        @(negedge clk);
        check("single virq 1clk", virq_n[0], 0);
        iack_cycle(0, 16'o000064, 4'b0010, 4'b0010, "single");
        check("single virq idle", virq_n[0], 1);

        // Fixed priority: 1 beats 3, then 3 alone
        req[0] = 4'b1010;
        repeat (2) @(negedge clk);
        check("fixed virq", virq_n[0], 0);
        iack_cycle(0, 16'o000064, 4'b0010, 4'b0010, "fixed1");
        check("fixed virq again", virq_n[0], 0);
        iack_cycle(0, 16'o000074, 4'b1000, 4'b1000, "fixed2");
        check("fixed virq idle", virq_n[0], 1);

        // Round robin with all four held: 0,1,2,3 then wrap to 0
        req[1] = 4'b1111;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("rr virq", virq_n[1], 0);
            iack_cycle(1, 16'(16'o60 + 4 * (k % 4)), 4'(4'b0001 << (k % 4)), 4'b0000, "rr");
        end
        req[1] = '0;
        repeat (4) @(negedge clk);

        // Withdrawal, then an unanswered vector cycle
        req[0] = 4'b0001;
        repeat (3) @(negedge clk);
        check("withdraw virq low", virq_n[0], 0);
        req[0] = 4'b0000;
        @(negedge clk);
        check("withdraw virq high", virq_n[0], 1);
        repeat (2) @(negedge clk);
        din_n  = 1'b0;
        iako_n = 1'b0;
        seen_r = 1'b0;
        seen_o = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (rply_n[0] !== 1'b1) seen_r = 1'b1;
            if (oe[0] !== 1'b0) seen_o = 1'b1;
        end
        check("noresp rply", seen_r, 0);
        check("noresp ad_oe", seen_o, 0);
        din_n  = 1'b1;
        iako_n = 1'b1;
        repeat (4) @(negedge clk);
        req[0] = 4'b0001;
        @(negedge clk);
        check("noresp recover virq", virq_n[0], 0);
        req[0] = 4'b0000;
        repeat (3) @(negedge clk);

        // Aborted cycle on the RPLY_DLY=5 instance
        req[2] = 4'b0001;
        repeat (2) @(negedge clk);
        check("abort virq", virq_n[2], 0);
        @(negedge clk);
        din_n  = 1'b0;
        iako_n = 1'b0;
        n = 0;
        while (oe[2] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort ad_oe", oe[2], 1);
        check("abort ad_out", ad[2], 16'o000060);
        @(negedge clk);
        din_n  = 1'b1;
        seen_r = 1'b0;
        seen_a = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rply_n[2] !== 1'b1) seen_r = 1'b1;
            if (ack[2] !== '0) seen_a = 1'b1;
        end
        check("abort rply", seen_r, 0);
        check("abort ack", seen_a, 0);
        check("abort ad_oe drop", oe[2], 0);
        iako_n = 1'b1;
        req[2] = '0;
        repeat (4) @(negedge clk);

        // Reset during HOLD
        req[0] = 4'b0001;
        repeat (2) @(negedge clk);
        @(negedge clk);
        din_n  = 1'b0;
        iako_n = 1'b0;
        n = 0;
        while (rply_n[0] !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst reach hold", rply_n[0], 0);
        @(negedge clk);
        init_n = 1'b0;
        #1;
        check("rst rply async", rply_n[0], 1);
        check("rst ad_oe async", oe[0], 0);
        check("rst virq async", virq_n[0], 1);
        check("rst ack async", ack[0], 0);
        din_n  = 1'b1;
        iako_n = 1'b1;
        seen_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack[0] !== '0) seen_a = 1'b1;
        end
        check("rst no ack", seen_a, 0);
        init_n = 1'b1;
        @(negedge clk);
        check("rst re-raise virq", virq_n[0], 0);
        check("rst rply idle", rply_n[0], 1);
        check("rst ad_oe idle", oe[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
